conv_frame_seq: RTL and testbench

//  Frame-level scheduler for the KxK streaming convolution datapath.
//  - Tracks input/output pixel coordinates.
//  - Gates pixel pushes into the line buffers and injects pad slots after the

---
 rtl/conv_frame_seq.sv | 142 ++++++++++++++
 tb/tb_conv_frame_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_seq.sv
// Frame-level slot scheduler for the KxK streaming convolution datapath: gates real pixel
// pushes, injects pad slots to flush the window, and produces the output-side markers.
module conv_frame_seq #(
  parameter int unsigned K          = 5,
  parameter int unsigned WIDTH_MAX  = 1920,
  parameter int unsigned HEIGHT_MAX = 1080,
  parameter int unsigned CW         = $clog2(WIDTH_MAX + 1),
  parameter int unsigned CH         = $clog2(HEIGHT_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cfg_width_i,
  input  logic [CH-1:0] cfg_height_i,
  input  logic          s_tvalid_i,
  input  logic          s_tuser_i,
  input  logic          s_tlast_i,
  output logic          s_tready_o,
  output logic          step_o,
  output logic          inject_o,
  output logic [CH-1:0] out_row_o,
  output logic [CW-1:0] out_col_o,
  input  logic          m_tready_i,
  output logic          m_tvalid_o,
  output logic          m_tuser_o,
  output logic          m_tlast_o,
  output logic          busy_o,
  output logic          err_sof_o,
  output logic          err_eol_o
);

  localparam int unsigned HK = K / 2;
  localparam int unsigned NW = CW + CH + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StFlush = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] w_q;
  logic [NW-1:0] n_q, p_q, slot_q;
  logic [CW-1:0] in_col_q;
  logic [CH-1:0] out_row_q;
  logic [CW-1:0] out_col_q;
  logic          m_tvalid_q, err_sof_q, err_eol_q;

  logic          stall, in_open, real_acc, sof_start, step, inject, emit;
  logic          sof_bad, eol_bad;
  logic [CW-1:0] eff_w, cur_col, in_col_next;
  logic [NW-1:0] n_new, p_new;

  always_comb begin
    stall     = m_tvalid_q & ~m_tready_i;
    in_open   = (state_q == StIdle) |
                (((state_q == StFill) | (state_q == StRun)) & (slot_q < n_q));
    s_tready_o = ~stall & in_open;
    real_acc  = s_tvalid_i & s_tready_o;
    sof_start = real_acc & s_tuser_i & (state_q == StIdle);
    inject    = (state_q == StFlush) & ~stall;
    // A non-SOF pixel in IDLE is swallowed without advancing the datapath.
    step      = inject | (real_acc & ((state_q != StIdle) | s_tuser_i));
    emit      = step & ((state_q == StRun) | (state_q == StFlush));

    n_new = NW'(cfg_width_i) * NW'(cfg_height_i);
    p_new = NW'(HK) * NW'(cfg_width_i) + NW'(HK);

    // The SOF pixel is checked against the width being latched with it.
    eff_w       = (state_q == StIdle) ? cfg_width_i : w_q;
    cur_col     = (state_q == StIdle) ? '0 : in_col_q;
    in_col_next = (cur_col == eff_w - CW'(1)) ? '0 : cur_col + CW'(1);

    sof_bad = real_acc & ((state_q == StIdle) ? ~s_tuser_i : s_tuser_i);
    eol_bad = step & ~inject & (s_tlast_i != (cur_col == eff_w - CW'(1)));

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sof_start) state_d = (p_new <= NW'(1)) ? StRun : StFill;
      StFill:  if (step && slot_q == p_q - NW'(1)) state_d = StRun;
      StRun:   if (step && slot_q == n_q - NW'(1)) state_d = StFlush;
      StFlush: if (step && slot_q == n_q + p_q - NW'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      w_q        <= '0;
      n_q        <= '0;
      p_q        <= '0;
      slot_q     <= '0;
      in_col_q   <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      m_tvalid_q <= 1'b0;
      err_sof_q  <= 1'b0;
      err_eol_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_sof_q <= sof_bad;
      err_eol_q <= eol_bad;

      if (sof_start) begin
        w_q      <= cfg_width_i;
        n_q      <= n_new;
        p_q      <= p_new;
        slot_q   <= NW'(1);
        in_col_q <= in_col_next;
      end else if (step) begin
        slot_q <= slot_q + NW'(1);
        if (!inject) in_col_q <= in_col_next;
      end

      if (emit) begin
        m_tvalid_q <= 1'b1;
        if (slot_q == p_q) begin
          out_row_q <= '0;
          out_col_q <= '0;
        end else if (out_col_q == w_q - CW'(1)) begin
          out_row_q <= out_row_q + CH'(1);
          out_col_q <= '0;
        end else begin
          out_col_q <= out_col_q + CW'(1);
        end
      end else if (m_tready_i) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign step_o     = step;
  assign inject_o   = inject;
  assign out_row_o  = out_row_q;
  assign out_col_o  = out_col_q;
  assign m_tvalid_o = m_tvalid_q;
  assign m_tuser_o  = m_tvalid_q & (out_row_q == '0) & (out_col_q == '0);
  assign m_tlast_o  = m_tvalid_q & (out_col_q == w_q - CW'(1));
  assign busy_o     = (state_q != StIdle);
  assign err_sof_o  = err_sof_q;
  assign err_eol_o  = err_eol_q;

endmodule

// File: tb/tb_conv_frame_seq.sv
// Bench for conv_frame_seq: frames are described by W, H and stall/gap patterns; expected
// slot counts, output raster order and markers come from the frame arithmetic directly.
module tb_conv_frame_seq;

  localparam int K  = 5;
  localparam int HK = K / 2;
  localparam int CW = $clog2(1920 + 1);
  localparam int CH = $clog2(1080 + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_width;
  logic [CH-1:0] cfg_height;
  logic          s_tvalid, s_tuser, s_tlast, s_tready;
  logic          step, inject;
  logic [CH-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          m_tready, m_tvalid, m_tuser, m_tlast;
  logic          busy, err_sof, err_eol;

  int checks = 0;
  int errors = 0;

  conv_frame_seq #(.K(K), .WIDTH_MAX(1920), .HEIGHT_MAX(1080)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_width_i  (cfg_width),
    .cfg_height_i (cfg_height),
    .s_tvalid_i   (s_tvalid),
    .s_tuser_i    (s_tuser),
    .s_tlast_i    (s_tlast),
    .s_tready_o   (s_tready),
    .step_o       (step),
    .inject_o     (inject),
    .out_row_o    (out_row),
    .out_col_o    (out_col),
    .m_tready_i   (m_tready),
    .m_tvalid_o   (m_tvalid),
    .m_tuser_o    (m_tuser),
    .m_tlast_o    (m_tlast),
    .busy_o       (busy),
    .err_sof_o    (err_sof),
    .err_eol_o    (err_eol)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tready"}, 32'(s_tready), 1);
    chk({tag, "_step"}, 32'(step), 0);
    chk({tag, "_inject"}, 32'(inject), 0);
    chk({tag, "_mvalid"}, 32'(m_tvalid), 0);
    chk({tag, "_muser"}, 32'(m_tuser), 0);
    chk({tag, "_mlast"}, 32'(m_tlast), 0);
    chk({tag, "_row"}, 32'(out_row), 0);
    chk({tag, "_col"}, 32'(out_col), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_esof"}, 32'(err_sof), 0);
    chk({tag, "_eeol"}, 32'(err_eol), 0);
  endtask

  // rdy_mode: 0 always ready, 1 low every third cycle, 2 random. rst_at < 0 disables reset.
  task automatic run_frame(input int w, input int h, input int rdy_mode, input int gaps,
                           input int bad_row, input int bad_col, input int rst_at);
    int n, p, pix, slots, beats, eols, sofs, dut_steps, dut_injs, first_slot, cyc;
    bit stall, acc, flush, exp_step;
    n = w * h;
    p = HK * w + HK;
    pix = 0; slots = 0; beats = 0; eols = 0; sofs = 0;
    dut_steps = 0; dut_injs = 0; first_slot = -1; cyc = 0;
    while (!(beats == n && slots == n + p) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (rst_at >= 0 && slots == rst_at) begin
        rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("midrst");
        return;
      end
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 3 != 0);
        default: m_tready = 1'($urandom_range(1));
      endcase
      s_tvalid   = (pix < n) && (gaps == 0 || $urandom_range(3) != 0);
      s_tuser    = (pix == 0);
      s_tlast    = ((pix % w) == w - 1) || ((pix / w) == bad_row && (pix % w) == bad_col);
      cfg_width  = (pix == 0) ? CW'(w) : CW'($urandom_range(30, K));
      cfg_height = (pix == 0) ? CH'(h) : CH'($urandom_range(30, K));
      #1;
      stall    = m_tvalid && !m_tready;
      flush    = (pix == n) && (slots < n + p);
      acc      = s_tvalid && s_tready;
      exp_step = acc || (flush && !stall);
      chk("s_tready", 32'(s_tready), 32'(!stall && (pix < n || slots == n + p)));
      chk("step", 32'(step), 32'(exp_step));
      chk("inject", 32'(inject), 32'(flush && !stall));
      if (slots > 0 && slots < n + p) chk("busy_mid", 32'(busy), 1);
      if (m_tvalid) begin
        if (first_slot < 0) first_slot = slots;
        chk("out_row", 32'(out_row), 32'(beats / w));
        chk("out_col", 32'(out_col), 32'(beats % w));
        chk("m_tuser", 32'(m_tuser), 32'(beats == 0));
        chk("m_tlast", 32'(m_tlast), 32'((beats % w) == w - 1));
        if (m_tready) begin
          beats++;
          if (beats == n) chk("busy_end", 32'(busy), 0);
        end
      end
      eols += int'(err_eol);
      sofs += int'(err_sof);
      dut_steps += int'(step);
      dut_injs  += int'(inject);
      if (exp_step) slots++;
      if (acc) pix++;
    end
    s_tvalid = 1'b0;
    chk("timeout", 32'(cyc < 5000), 1);
    chk("beats", 32'(beats), 32'(n));
    chk("steps_total", 32'(dut_steps), 32'(n + p));
    chk("inject_total", 32'(dut_injs), 32'(p));
    chk("first_beat_slot", 32'(first_slot), 32'(p + 1));
    chk("err_eol_count", 32'(eols), 32'(bad_row >= 0 ? 1 : 0));
    chk("err_sof_count", 32'(sofs), 0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_width = '0; cfg_height = '0;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    run_frame(8, 6, 0, 0, -1, -1, -1);
    run_frame(8, 6, 1, 0, -1, -1, -1);

    // Stray pixel in IDLE: swallowed with an SOF error, then a normal frame.
    @(negedge clk);
    s_tvalid = 1'b1; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    #1;
    chk("stray_tready", 32'(s_tready), 1);
    chk("stray_step", 32'(step), 0);
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    chk("stray_err_sof", 32'(err_sof), 1);
    @(negedge clk);
    #1;
    chk("stray_err_sof_pulse", 32'(err_sof), 0);
    chk("stray_busy", 32'(busy), 0);
    run_frame(8, 6, 0, 0, -1, -1, -1);

    run_frame(8, 6, 0, 0, 2, 5, -1);

    run_frame(8, 6, 0, 0, -1, -1, 30);
    run_frame(5, 5, 0, 0, -1, -1, -1);

    run_frame(8, 6, 0, 0, -1, -1, -1);
    run_frame(16, 5, 0, 0, -1, -1, -1);

    for (int f = 0; f < 3; f++) begin
      run_frame($urandom_range(12, 5), $urandom_range(8, 5), 2, 1, -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
